// File: rtl/xnor3_selftest_pkg.sv
// Shared types and helpers for the three-input XNOR self-test sequencer.
package xnor3_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 8;

  // Golden response of the datapath under test: y = ~(a ^ b ^ c)
  function automatic logic xnor3_golden(input logic [2:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/xnor3_settle_timer.sv
// Settle-time down-counter: loaded with SETTLE_CYCLES-1, counts down while
// enabled and reports expiry on the last settle cycle of a vector.
module xnor3_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Reload on request, otherwise count down to zero while the settle phase runs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (en && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = en && (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/xnor3_selftest_ctrl.sv
// Self-test sequencer for the three-input XNOR datapath. Sweeps all eight
// input vectors PASSES times, holds each for SETTLE_CYCLES before sampling y,
// and reports error count, first failing vector and pass/fail.
// Optional build macro XNOR3_SELFTEST_FAILMAP_EN adds a per-vector fail_map.
module xnor3_selftest_ctrl
  import xnor3_selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       first_fail_vec
`ifdef XNOR3_SELFTEST_FAILMAP_EN
  ,
  output logic [7:0]       fail_map
`endif
);

  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW-1:0]    PIDX_ONE  = PW'(1);
  localparam logic [PW-1:0]    PIDX_LAST = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO  = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

  state_t           state_r;
  logic [2:0]       vec_r;
  logic [PW-1:0]    pidx_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [ERR_W-1:0] err_r;
  logic             fv_r;
  logic [2:0]       ffv_r;
`ifdef XNOR3_SELFTEST_FAILMAP_EN
  logic [7:0]       fmap_r;
`endif

  logic             load_s;
  logic             tmr_en_s;
  logic             expire_s;
  logic             mismatch_s;
  logic             last_s;
  logic [ERR_W-1:0] err_next_s;

  // Timer restarts at every accepted start and after every check
  assign load_s   = ((state_r == IDLE) && start) || (state_r == CHECK);
  assign tmr_en_s = (state_r == SETTLE);

  xnor3_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load_s),
    .en     (tmr_en_s),
    .expire (expire_s)
  );

  // Compare the sampled response and form the saturating next error count
  always_comb begin
    mismatch_s = 1'b0;
    err_next_s = err_r;
    last_s     = (vec_r == 3'd7) && (pidx_r == PIDX_LAST);
    if (state_r == CHECK) begin
      mismatch_s = (y != xnor3_golden(vec_r));
    end else begin
      mismatch_s = 1'b0;
    end
    if (mismatch_s && (err_r != ERR_MAX)) begin
      err_next_s = err_r + ERR_ONE;
    end else begin
      err_next_s = err_r;
    end
  end

  // Sequencer state machine with all status outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      vec_r   <= 3'd0;
      pidx_r  <= {PW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= ERR_ZERO;
      fv_r    <= 1'b0;
      ffv_r   <= 3'd0;
`ifdef XNOR3_SELFTEST_FAILMAP_EN
      fmap_r  <= 8'd0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= SETTLE;
            vec_r   <= 3'd0;
            pidx_r  <= {PW{1'b0}};
            busy_r  <= 1'b1;
            pass_r  <= 1'b0;
            err_r   <= ERR_ZERO;
            fv_r    <= 1'b0;
            ffv_r   <= 3'd0;
`ifdef XNOR3_SELFTEST_FAILMAP_EN
            fmap_r  <= 8'd0;
`endif
          end
        end
        SETTLE: begin
          if (expire_s) begin
            state_r <= CHECK;
          end
        end
        CHECK: begin
          err_r <= err_next_s;
          if (mismatch_s && !fv_r) begin
            fv_r  <= 1'b1;
            ffv_r <= vec_r;
          end
`ifdef XNOR3_SELFTEST_FAILMAP_EN
          if (mismatch_s) begin
            fmap_r[vec_r] <= 1'b1;
          end
`endif
          if (last_s) begin
            // Park the vector at zero so a=b=c=0 in DONE and IDLE
            state_r <= DONE;
            vec_r   <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == ERR_ZERO);
          end else begin
            if (vec_r == 3'd7) begin
              pidx_r <= pidx_r + PIDX_ONE;
            end
            vec_r   <= vec_r + 3'd1;
            state_r <= SETTLE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          vec_r   <= 3'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign {a, b, c}      = vec_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_r;
  assign fail_valid     = fv_r;
  assign first_fail_vec = ffv_r;
`ifdef XNOR3_SELFTEST_FAILMAP_EN
  assign fail_map       = fmap_r;
`endif

endmodule

// File: doc/xnor3_selftest_ctrl.md
Name: xnor3_selftest_ctrl

Overview:
Self-test sequencer for the three-input XNOR datapath (y = ~(a ^ b ^ c)).
- Drives a, b, c through all 8 input vectors, waits a settle time, samples y and compares it with the golden value.
- Reports error count, first failing vector and pass/fail over a start/done handshake.
- Sits between the bring-up control logic and the XNOR instance under test.

Parameters:
- SETTLE_CYCLES, 1: cycles each vector is held before y is sampled; legal range ≥1.
- PASSES, 1: number of full 8-vector sweeps per run; legal range ≥1.
- ERR_W, 4: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- a  out  1  vector bit 2 (MSB) to the XNOR.
- b  out  1  vector bit 1.
- c  out  1  vector bit 0.
- y  in  1  XNOR output under test.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  1 when err_count==0 at run end; held until the next start.
- err_count  out  ERR_W  mismatch count; saturates at 2^ERR_W-1.
- fail_valid  out  1  at least one mismatch has occurred in this run.
- first_fail_vec  out  3  {a,b,c} of the first mismatch; valid when fail_valid=1.

Behaviour:
- Reset (synchronous): state=IDLE, vec=0, a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0, settle timer=0, pass index=0.
- {a,b,c} is driven directly from the registered vec, so there is no combinational path from y.
- State machine:
  - IDLE: if start=1, clear err_count, fail_valid, first_fail_vec and pass; set vec=0 and pass index=0; go to SETTLE. a=b=c=0 while in IDLE.
  - SETTLE: timer counts 0..SETTLE_CYCLES-1; on the last count go to CHECK.
  - CHECK (1 cycle): mismatch = (y != ~(a^b^c)).
    - On mismatch: err_count increments unless saturated. If fail_valid=0, capture first_fail_vec=vec and set fail_valid=1.
    - If vec==7 and pass index==PASSES-1, go to DONE.
    - Otherwise vec wraps 7→0 (pass index increments on the wrap) or increments; go to SETTLE.
  - DONE (1 cycle): done=1; pass=(err_count==0); go to IDLE.
- busy=1 in SETTLE and CHECK only.
- Latency: start is sampled at edge E0. busy is high for 8·PASSES·(SETTLE_CYCLES+1) cycles; done pulses in the next cycle. Defaults give 16 busy cycles, with done in cycle 17.
- start during SETTLE, CHECK or DONE is ignored (it is not queued).
- Reset mid-run aborts immediately to the reset values; no done pulse is produced.
- err_count, fail_valid and first_fail_vec stay readable after DONE until the next accepted start.

Optional Feature:
XNOR3_SELFTEST_FAILMAP_EN
- Defined: adds output port fail_map [7:0].
  - Bit vec is set on a mismatch at that vector (any pass).
  - Cleared at start and at reset.
  - Held after DONE.
- Undefined: no port and no register; all other behaviour is identical.

Decomposition:
- Package xnor3_selftest_pkg contains:
  - typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t
  - localparam NUM_VECTORS = 8
  - function xnor3_golden(logic [2:0] v) returning ~^v
- One sub-module, xnor3_settle_timer: load/count/expire down-counter parameterised by SETTLE_CYCLES, instantiated once.

Test Plan:
- Correct XNOR connected, defaults, start pulse → vectors 000..111 each held 2 cycles; busy high 16 cycles; done pulse once; pass=1, err_count=0, fail_valid=0.
- y stuck at 0 → err_count=4 (expected-1 vectors 000, 011, 101, 110); first_fail_vec=3'b000; pass=0; fail_map=8'b0110_1001 with XNOR3_SELFTEST_FAILMAP_EN.
- y = a^b^c (inverted), ERR_W=2 → err_count saturates at 3; first_fail_vec=3'b000; fail_map=8'hFF with the feature enabled.
- y stuck at 1, PASSES=2, SETTLE_CYCLES=3 → busy 64 cycles; err_count=8; first_fail_vec=3'b001.
- start re-asserted every cycle while busy → exactly one done pulse; a second start after done → new run with counters cleared.
- reset asserted at the 5th busy cycle → next cycle state=IDLE, a=b=c=0, busy=0, err_count=0; no done pulse.
